chunked_adder: RTL and testbench
================================

CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 8: bits added per cycle.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid_i, input, 1: operands valid.
REQ-006 SHALL have port in_ready_o, output, 1: block can accept operands.
REQ-007 SHALL have port a_i, input, WORD_WIDTH: operand A.
REQ-008 SHALL have port b_i, input, WORD_WIDTH: operand B.
REQ-009 SHALL have port c_i, input, 1: carry-in (add) / borrow-in (sub).
REQ-010 SHALL have port sub_i, input, 1: 0 = A+B+c_i, 1 = A-B-c_i.
REQ-011 SHALL have port out_valid_o, output, 1: result valid.
REQ-012 SHALL have port out_ready_i, input, 1: consumer accepts result.
REQ-013 SHALL have port r_o, output, WORD_WIDTH: result.
REQ-014 SHALL have port c_o, output, 1: raw carry-out of MSB chunk (sub: 1 = no borrow).
REQ-015 SHALL have port v_o, output, 1: two's-complement signed overflow.

Function
REQ-016 SHALL raise an elaboration error unless CHUNK_WIDTH >= 1 and WORD_WIDTH % CHUNK_WIDTH == 0; NCHUNK = WORD_WIDTH/CHUNK_WIDTH.
REQ-017 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-018 SHALL assert in_ready_o only in IDLE; accept when in_valid_i && in_ready_o, latching a_i, b_i ^ {WORD_WIDTH{sub_i}}, carry seed c_i ^ sub_i, then enter BUSY.
REQ-019 SHALL in BUSY add one chunk per cycle, LSB chunk first, carry registered between chunks; chunk counter 0..NCHUNK-1.
REQ-020 SHALL enter DONE on the edge completing chunk NCHUNK-1; out_valid_o rises exactly NCHUNK cycles after the accept edge (NCHUNK=1 gives latency 1).
REQ-021 SHALL hold r_o, c_o, v_o stable while out_valid_o is high; v_o = carry into MSB XOR carry out of MSB.
REQ-022 SHALL leave DONE for IDLE on the edge where out_ready_i is high; no accept in the same cycle (one-cycle bubble between results).
REQ-023 SHALL ignore in_valid_i, a_i, b_i, c_i, sub_i outside IDLE; changes on them SHALL not affect an operation in flight.
REQ-024 SHALL keep r_o, c_o, v_o at the last result after returning to IDLE until the next DONE.

Reset
REQ-025 SHALL on rst_i high at a clock edge go to IDLE, clear chunk counter and carry, set in_ready_o=1, out_valid_o=0, r_o=0, c_o=0, v_o=0.
REQ-026 SHALL abort any BUSY/DONE operation on reset with no result ever presented for it; reset takes priority over every other event.

Structure
REQ-027 SHALL place the FSM state enum typedef in shared package adder_pkg.
REQ-028 SHALL compute each chunk with one instance of the existing ripple-carry adder RCA_M, WORD_WIDTH=CHUNK_WIDTH, carry-in from the registered carry.
REQ-029 SHALL use shift registers for operands/result (no wide per-chunk multiplexers).

Verification (WORD_WIDTH=8, CHUNK_WIDTH=2, NCHUNK=4)
REQ-030 SHALL check add 100+27, c_i=0 -> r_o=127, c_o=0, v_o=0, out_valid_o high exactly 4 cycles after accept.
REQ-031 SHALL check 0xFF+0x01 -> r_o=0x00, c_o=1, v_o=0; 0x7F+0x01 -> r_o=0x80, c_o=0, v_o=1.
REQ-032 SHALL check sub 0x05-0x07 -> r_o=0xFE, c_o=0, v_o=0; 0x80-0x01 -> r_o=0x7F, c_o=1, v_o=1; 0x10-0x00 with c_i=1 -> r_o=0x0F.
REQ-033 SHALL check backpressure: out_ready_i low 5 cycles -> out_valid_o, r_o held, in_ready_o low, in_valid_i pulses ignored; result leaves on out_ready_i, in_ready_o high next cycle.
REQ-034 SHALL check reset asserted in 2nd BUSY cycle -> next cycle IDLE, in_ready_o=1, out_valid_o=0, r_o=0; following 0x33+0x44 -> 0x77.
REQ-035 SHALL check randomized back-to-back operations against a reference model: (a op b op c) mod 256, carry and overflow.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types for the multi-cycle chunked adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/RCA_M.sv
// Plain ripple-carry adder: s_o = a_i + b_i + c_i, carry-out on c_o.
module RCA_M #(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  input  logic                  c_i,
  output logic [WORD_WIDTH-1:0] s_o,
  output logic                  c_o
);

  logic [WORD_WIDTH:0] carry;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    carry    = '0;
    s_o      = '0;
    carry[0] = c_i;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    c_o = carry[WORD_WIDTH];
  end

endmodule

// File: rtl/chunked_adder.sv
// Serial add/subtract: one CHUNK_WIDTH slice per cycle, LSB first, valid/ready on both sides.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  input  logic                  c_i,
  input  logic                  sub_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WORD_WIDTH-1:0] r_o,
  output logic                  c_o,
  output logic                  v_o
);

  localparam int NCHUNK = WORD_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  if (CHUNK_WIDTH < 1 || (WORD_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_params
    $error("chunked_adder: WORD_WIDTH must be a positive multiple of CHUNK_WIDTH");
  end

  state_t state, state_nxt;

  logic [WORD_WIDTH-1:0]  a_sr, b_sr, a_shift, r_q;
  logic [CHUNK_WIDTH-1:0] sum;
  logic [CNT_W-1:0]       cnt_q;
  logic                   carry_q, carry_out, msb_cin, c_q, v_q;
  logic                   accept, busy, last_chunk;

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign accept      = in_valid_i && in_ready_o;
  assign busy        = (state == BUSY);
  assign last_chunk  = busy && (cnt_q == LAST_CHUNK);

  RCA_M #(.WORD_WIDTH(CHUNK_WIDTH)) u_rca (
    .a_i (a_sr[CHUNK_WIDTH-1:0]),
    .b_i (b_sr[CHUNK_WIDTH-1:0]),
    .c_i (carry_q),
    .s_o (sum),
    .c_o (carry_out)
  );

  // Carry into the MSB is recovered from the MSB sum bit, so the adder needs no extra port.
  assign msb_cin = a_sr[CHUNK_WIDTH-1] ^ b_sr[CHUNK_WIDTH-1] ^ sum[CHUNK_WIDTH-1];

  // Result chunks fill the vacated top of the A register; after NCHUNK shifts it holds the sum.
  if (NCHUNK == 1) begin : g_single
    assign a_shift = sum;
  end else begin : g_multi
    assign a_shift = {sum, a_sr[WORD_WIDTH-1:CHUNK_WIDTH]};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid_i)  state_nxt = BUSY;
      BUSY:    if (last_chunk)  state_nxt = DONE;
      DONE:    if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: operand shift registers carry no reset; they are always loaded before being used.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_sr <= a_i;
      b_sr <= b_i ^ {WORD_WIDTH{sub_i}};
    end else if (busy) begin
      a_sr <= a_shift;
      b_sr <= b_sr >> CHUNK_WIDTH;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      r_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      carry_q <= c_i ^ sub_i;
    end else if (busy) begin
      cnt_q   <= cnt_q + 1'b1;
      carry_q <= carry_out;
      if (last_chunk) begin
        r_q <= a_shift;
        c_q <= carry_out;
        v_q <= carry_out ^ msb_cin;
      end
    end
  end

  assign r_o = r_q;
  assign c_o = c_q;
  assign v_o = v_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder (8-bit word, 2-bit chunks) against an integer reference model.
module tb_chunked_adder;

  localparam int W   = 8;
  localparam int C   = 2;
  localparam int NCH = W / C;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         c_i = 1'b0;
  logic         sub_i = 1'b0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b1;
  logic [W-1:0] r_o;
  logic         c_o;
  logic         v_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  chunked_adder #(.WORD_WIDTH(W), .CHUNK_WIDTH(C)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .c_i         (c_i),
    .sub_i       (sub_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .r_o         (r_o),
    .c_o         (c_o),
    .v_o         (v_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations of the operands.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic c,
                                input logic sub, output logic [7:0] r, output logic co,
                                output logic v);
    int ua, ub, sa, sb, u, s;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    if (sub) begin
      u  = ua - ub - int'(c);
      s  = sa - sb - int'(c);
      co = (u >= 0);
    end else begin
      u  = ua + ub + int'(c);
      s  = sa + sb + int'(c);
      co = (u > 255);
    end
    r = 8'(u & 255);
    v = (s > 127) || (s < -128);
  endfunction

  // Returns #1 after the accept edge, with junk left on the operand inputs.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sub);
    int guard = 0;
    @(negedge clk);
    while (!in_ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", 32'(in_ready_o), 32'd1);
    a_i = a; b_i = b; c_i = c; sub_i = sub;
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    a_i = 8'($urandom); b_i = 8'($urandom); c_i = 1'($urandom); sub_i = 1'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic c, input logic sub, input int lat);
    logic [7:0] r_exp;
    logic       c_exp, v_exp;
    model(a, b, c, sub, r_exp, c_exp, v_exp);
    check({tag, "_latency"}, 32'(lat), 32'(NCH));
    check({tag, "_r"}, 32'(r_o), 32'(r_exp));
    check({tag, "_c"}, 32'(c_o), 32'(c_exp));
    check({tag, "_v"}, 32'(v_o), 32'(v_exp));
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic sub);
    int lat;
    start_op(a, b, c, sub);
    wait_result(lat);
    expect_result(tag, a, b, c, sub, lat);
    @(posedge clk); #1;
    check({tag, "_drain_valid"}, 32'(out_valid_o), 32'd0);
    check({tag, "_drain_ready"}, 32'(in_ready_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r_exp;
    logic       c_exp, v_exp;
    int         lat;
    int         seen;

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready_o), 32'd1);
    check("reset_out_valid", 32'(out_valid_o), 32'd0);
    check("reset_r", 32'(r_o), 32'd0);
    check("reset_c", 32'(c_o), 32'd0);
    check("reset_v", 32'(v_o), 32'd0);
    rst_i = 1'b0;

    run_op("add_100_27", 8'd100, 8'd27, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1);
    run_op("sub_10_00_b", 8'h10, 8'h00, 1'b1, 1'b1);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0);

    // Backpressure: result held for five cycles while stray input requests are offered.
    out_ready_i = 1'b0;
    start_op(8'h5A, 8'h23, 1'b0, 1'b0);
    wait_result(lat);
    expect_result("bp", 8'h5A, 8'h23, 1'b0, 1'b0, lat);
    model(8'h5A, 8'h23, 1'b0, 1'b0, r_exp, c_exp, v_exp);
    for (int i = 0; i < 5; i++) begin
      in_valid_i = (i % 2) == 0;
      a_i = 8'($urandom); b_i = 8'($urandom);
      @(posedge clk); #1;
      check("bp_valid_held", 32'(out_valid_o), 32'd1);
      check("bp_r_held", 32'(r_o), 32'(r_exp));
      check("bp_in_ready_low", 32'(in_ready_o), 32'd0);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid_o), 32'd0);
    check("bp_release_ready", 32'(in_ready_o), 32'd1);
    check("bp_r_kept_idle", 32'(r_o), 32'(r_exp));

    // Reset in the second BUSY cycle aborts the operation.
    start_op(8'hAA, 8'h11, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("abort_in_ready", 32'(in_ready_o), 32'd1);
    check("abort_out_valid", 32'(out_valid_o), 32'd0);
    check("abort_r", 32'(r_o), 32'd0);
    check("abort_c", 32'(c_o), 32'd0);
    check("abort_v", 32'(v_o), 32'd0);
    seen = 0;
    repeat (NCH + 2) begin
      @(posedge clk); #1;
      if (out_valid_o) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    run_op("after_abort", 8'h33, 8'h44, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
